// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared graphics constants and frame scheduler state encoding
package gfx_pkg;

   localparam int COLOR_DEPTH    = 9;
   localparam int SCREEN_TILES_X = 20;
   localparam int SCREEN_TILES_Y = 15;
   localparam int TILEMAP_LENGTH = 2000;
   localparam int X_OFFSET_MAX   = TILEMAP_LENGTH - SCREEN_TILES_X;
   localparam int X_OFFSET_W     = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BG_RUN,
      ST_BG_REL,
      ST_SPR_SEL,
      ST_SPR_RUN,
      ST_SPR_REL,
      ST_FINISH
   } sched_state_t;

endpackage

// File: rtl/frame_draw_scheduler_if.sv
// rtl/frame_draw_scheduler_if.sv - drawer handshakes, pixel streams and VGA write port
interface frame_draw_scheduler_if #(
   parameter int NUM_SPRITES = 2,
   parameter int COLOR_DEPTH = gfx_pkg::COLOR_DEPTH
) ();

   logic                               bg_enable;
   logic                               bg_done;
   logic [7:0]                         bg_x;
   logic [6:0]                         bg_y;
   logic [COLOR_DEPTH-1:0]             bg_color;
   logic                               bg_plot;

   logic [NUM_SPRITES-1:0]             spr_enable;
   logic [NUM_SPRITES-1:0]             spr_done;
   logic [8*NUM_SPRITES-1:0]           spr_x;
   logic [7*NUM_SPRITES-1:0]           spr_y;
   logic [COLOR_DEPTH*NUM_SPRITES-1:0] spr_color;
   logic [NUM_SPRITES-1:0]             spr_plot;

   logic [7:0]                         vga_x;
   logic [6:0]                         vga_y;
   logic [COLOR_DEPTH-1:0]             vga_color;
   logic                               vga_plot;

   modport master (
      output bg_enable, spr_enable, vga_x, vga_y, vga_color, vga_plot,
      input  bg_done, bg_x, bg_y, bg_color, bg_plot,
      input  spr_done, spr_x, spr_y, spr_color, spr_plot
   );

   modport slave (
      input  bg_enable, spr_enable, vga_x, vga_y, vga_color, vga_plot,
      output bg_done, bg_x, bg_y, bg_color, bg_plot,
      output spr_done, spr_x, spr_y, spr_color, spr_plot
   );

endinterface

// File: rtl/scroll_offset_reg.sv
// rtl/scroll_offset_reg.sv - pending scroll latch and saturating x_offset counter
module scroll_offset_reg #(
   parameter int X_OFFSET_MAX = gfx_pkg::X_OFFSET_MAX
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          scroll_right,
   input  logic                          scroll_left,
   input  logic                          apply,
   output logic [gfx_pkg::X_OFFSET_W-1:0] x_offset
);
   import gfx_pkg::*;

   localparam logic [X_OFFSET_W-1:0] OFF_MAX = X_OFFSET_W'(X_OFFSET_MAX);

   logic pend_r;
   logic pend_l;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pend_r   <= 1'b0;
         pend_l   <= 1'b0;
         x_offset <= '0;
      end else if (apply) begin
         // pulses coinciding with the apply strobe belong to the next frame
         pend_r <= scroll_right;
         pend_l <= scroll_left;
         if (pend_r && !pend_l && x_offset != OFF_MAX)
            x_offset <= x_offset + 1'b1;
         else if (pend_l && !pend_r && x_offset != '0)
            x_offset <= x_offset - 1'b1;
      end else begin
         if (scroll_right) pend_r <= 1'b1;
         if (scroll_left)  pend_l <= 1'b1;
      end
   end

endmodule

// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - sequences background then sprites onto the shared VGA port
module frame_draw_scheduler #(
   parameter int NUM_SPRITES  = 2,
   parameter int COLOR_DEPTH  = gfx_pkg::COLOR_DEPTH,
   parameter int X_OFFSET_MAX = gfx_pkg::X_OFFSET_MAX
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic                           frame_tick,
   input  logic                           scroll_right,
   input  logic                           scroll_left,
   input  logic [NUM_SPRITES-1:0]         spr_active,
   frame_draw_scheduler_if.master         bus,
   output logic [gfx_pkg::X_OFFSET_W-1:0] x_offset,
   output logic                           busy,
   output logic                           overrun
);
   import gfx_pkg::*;

   localparam int IDX_W = $clog2(NUM_SPRITES + 1);
   localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   sched_state_t           state, state_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt;
   logic [SEL_W-1:0]       sel;
   logic [NUM_SPRITES-1:0] act_mask, act_nxt;
   logic                   start;

   logic [7:0]             sx [NUM_SPRITES];
   logic [6:0]             sy [NUM_SPRITES];
   logic [COLOR_DEPTH-1:0] sc [NUM_SPRITES];

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_unpack
      assign sx[g] = bus.spr_x[8*g +: 8];
      assign sy[g] = bus.spr_y[7*g +: 7];
      assign sc[g] = bus.spr_color[COLOR_DEPTH*g +: COLOR_DEPTH];
   end

   assign sel  = idx[SEL_W-1:0];
   assign busy = (state != ST_IDLE);

   scroll_offset_reg #(.X_OFFSET_MAX(X_OFFSET_MAX)) u_scroll (
      .clock        (clock),
      .resetn       (resetn),
      .scroll_right (scroll_right),
      .scroll_left  (scroll_left),
      .apply        (start),
      .x_offset     (x_offset)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         idx      <= '0;
         act_mask <= '0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         act_mask <= act_nxt;
         if (frame_tick && state != ST_IDLE) overrun <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      act_nxt   = act_mask;
      start     = 1'b0;
      case (state)
         ST_IDLE: if (frame_tick) begin
            start     = 1'b1;
            act_nxt   = spr_active;
            state_nxt = ST_BG_RUN;
         end
         ST_BG_RUN: if (bus.bg_done) state_nxt = ST_BG_REL;
         // drawers hold done until enable falls, so wait for it to clear
         ST_BG_REL: if (!bus.bg_done) begin
            idx_nxt   = '0;
            state_nxt = ST_SPR_SEL;
         end
         ST_SPR_SEL: begin
            if (idx == IDX_W'(NUM_SPRITES)) state_nxt = ST_FINISH;
            else if (act_mask[sel])         state_nxt = ST_SPR_RUN;
            else                            idx_nxt   = idx + 1'b1;
         end
         ST_SPR_RUN: if (bus.spr_done[sel]) state_nxt = ST_SPR_REL;
         ST_SPR_REL: if (!bus.spr_done[sel]) begin
            idx_nxt   = idx + 1'b1;
            state_nxt = ST_SPR_SEL;
         end
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.bg_enable  = (state == ST_BG_RUN);
      bus.spr_enable = '0;
      if (state == ST_SPR_RUN) bus.spr_enable[sel] = 1'b1;
   end

   // coordinates hold their last value whenever nobody owns the port
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bus.vga_x     <= '0;
         bus.vga_y     <= '0;
         bus.vga_color <= '0;
         bus.vga_plot  <= 1'b0;
      end else begin
         bus.vga_plot <= 1'b0;
         if (state == ST_BG_RUN) begin
            bus.vga_x     <= bus.bg_x;
            bus.vga_y     <= bus.bg_y;
            bus.vga_color <= bus.bg_color;
            bus.vga_plot  <= bus.bg_plot;
         end else if (state == ST_SPR_RUN) begin
            bus.vga_x     <= sx[sel];
            bus.vga_y     <= sy[sel];
            bus.vga_color <= sc[sel];
            bus.vga_plot  <= bus.spr_plot[sel];
         end
      end
   end

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Sequences one full frame redraw and shares the single VGA adapter write port between the background drawer and NUM_SPRITES sprite drawers.
- Order per frame: background first, then the sprites in index order, so sprites overwrite the background.
- Owns the scroll position (x_offset). It applies pending scroll steps only at frame start, so the background never tears mid-frame.
- Sits between the game-logic frame tick and the drawing engines and VGA adapter.

Parameters:
- NUM_SPRITES, 2, number of sprite draw clients (1..8).
- COLOR_DEPTH, 9, VGA colour width in bits.
- X_OFFSET_MAX, 1980, largest legal x_offset (tilemap length 2000 minus 20 screen tiles).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse requesting a frame redraw
- scroll_right  in  1  one-cycle pulse, request x_offset+1
- scroll_left  in  1  one-cycle pulse, request x_offset-1
- spr_active  in  NUM_SPRITES  per-sprite draw enable, sampled at frame start
- bg_enable  out  1  level enable to background drawer
- bg_done  in  1  background drawer done
- bg_x / bg_y / bg_color / bg_plot  in  8 / 7 / COLOR_DEPTH / 1  background pixel stream
- spr_enable  out  NUM_SPRITES  one-hot level enable to sprite drawers
- spr_done  in  NUM_SPRITES  sprite done flags
- spr_x / spr_y / spr_color  in  8*N / 7*N / COLOR_DEPTH*N  packed sprite pixel streams; sprite i occupies slice i
- spr_plot  in  NUM_SPRITES  sprite plot strobes
- vga_x / vga_y / vga_color / vga_plot  out  8 / 7 / COLOR_DEPTH / 1  to VGA adapter
- x_offset  out  11  current scroll position (tile units)
- busy  out  1  high from frame start until FINISH
- overrun  out  1  sticky: a frame_tick arrived while busy

Behaviour:
- Reset (async): state IDLE; all enables 0; vga_* 0; x_offset 0; pending scroll flags 0; overrun 0; busy 0.
- Client handshake (level): raise enable; hold it until done=1; drop enable; wait for done=0 before selecting the next client. This is required because drawers hold done until enable falls.
- Scroll requests are latched into pend_r/pend_l at any time.
  - If both are set at frame start, they cancel.
  - At the IDLE->BG_RUN transition: x_offset += 1 (saturates at X_OFFSET_MAX) or x_offset -= 1 (saturates at 0). Both pending flags clear.
  - A scroll pulse arriving in the same cycle as the frame start is applied next frame.
- States:
  - IDLE: on frame_tick, latch spr_active into act_mask, update x_offset, go to BG_RUN.
  - BG_RUN: bg_enable=1; when bg_done=1, go to BG_REL.
  - BG_REL: bg_enable=0; when bg_done=0, set idx=0 and go to SPR_SEL.
  - SPR_SEL: if idx==NUM_SPRITES, go to FINISH. Else if act_mask[idx], go to SPR_RUN. Else idx++ (one cycle per skipped sprite).
  - SPR_RUN: spr_enable[idx]=1; when spr_done[idx]=1, go to SPR_REL.
  - SPR_REL: when spr_done[idx]=0, idx++ and go to SPR_SEL.
  - FINISH: one cycle, busy still 1; next state IDLE.
- busy = (state != IDLE).
- frame_tick while busy (including FINISH): tick is dropped and overrun is set. overrun clears only on reset.
- Pixel mux, registered with 1-cycle latency:
  - vga_x/y/color follow the owning client (background in BG_RUN, sprite idx in SPR_RUN).
  - vga_plot = owner's plot, registered, only in RUN states; otherwise 0.
  - vga_x/y/color hold their last value when no client owns the port.
- Client plot strobes outside its RUN state are ignored.
- Mid-operation reset: all enables drop immediately (async). Drawers share resetn.

Decomposition:
- Shared package gfx_pkg: state encoding, COLOR_DEPTH, SCREEN_TILES_X=20, SCREEN_TILES_Y=15, TILEMAP_LENGTH=2000, X_OFFSET_MAX.
- One natural sub-module: scroll_offset_reg (pending-flag latch + saturating up/down counter, apply strobe input).

Test Plan:
- Reset, frame_tick, spr_active=2'b11; background model done after 10 cycles, sprites after 5 -> bg_enable high 10 cycles, then spr_enable 01 then 10; busy falls 1 cycle after FINISH; vga_plot equals the owner's plot delayed 1 cycle.
- spr_active=2'b10 -> spr_enable[0] never asserts; only sprite 1 drawn; exactly one SPR_SEL skip cycle.
- 3 scroll_right pulses in one frame, then frame_tick -> x_offset 0->1 (not 3); scroll_left at x_offset=0 -> stays 0; at 1980, scroll_right -> stays 1980.
- scroll_right and scroll_left both pending, frame_tick -> x_offset unchanged.
- frame_tick during BG_RUN -> overrun=1 and stays 1; no second frame starts; next tick after IDLE starts a frame normally.
- Background model holds done=1 for 4 cycles after enable drops -> scheduler stays in BG_REL; spr_enable stays 0 until bg_done=0. Assert resetn low mid-SPR_RUN -> all enables and vga_plot go 0 asynchronously.
